// File: rtl/wb_pwm_pkg.sv
// Shared constants, request payload and byte-lane helper for the Wishbone PWM slave.
package wb_pwm_pkg;

    localparam int unsigned CW_DEFAULT = 16;

    localparam logic [7:0] CTRL_OFF   = 8'h00;
    localparam logic [7:0] PRESC_OFF  = 8'h04;
    localparam logic [7:0] STATUS_OFF = 8'h08;
    localparam logic [7:0] IRQEN_OFF  = 8'h0C;
    localparam logic [7:0] CH_BASE    = 8'h10;
    localparam logic [7:0] CH_STRIDE  = 8'h08;

    localparam int unsigned CLR_BIT = 31;

    // Decoded Wishbone write request as seen by the register file
    typedef struct packed {
        logic        wr;
        logic [3:0]  sel;
        logic [5:0]  widx;
        logic [31:0] dat;
    } wb_req_t;

    // Replace the byte lanes selected by sel with the new data
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_pwm_slave_channel.sv
// One PWM channel: free-running counter with period/duty shadows reloaded at each wrap.
module pwm_channel
    import wb_pwm_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] period_i,
    input  logic [CW-1:0] duty_i,
    output logic          pwm_o,
    output logic          wrap_c
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] p_sh_q, p_sh_d;
    logic [CW-1:0] d_sh_q, d_sh_d;
    logic          en_q;
    logic          pwm_q, pwm_d;

    // Counter, shadow reload and waveform compare
    always_comb begin
        cnt_d  = cnt_q;
        p_sh_d = p_sh_q;
        d_sh_d = d_sh_q;
        wrap_c = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (!en_q) begin
            // Enable rising edge: start a fresh period with the programmed values
            cnt_d  = '0;
            p_sh_d = period_i;
            d_sh_d = duty_i;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == p_sh_q) begin
                cnt_d  = '0;
                wrap_c = 1'b1;
                p_sh_d = period_i;
                d_sh_d = duty_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // Shadows are stale until the enable edge has been seen, so hold low one cycle
        pwm_d = en_i & en_q & (cnt_q < d_sh_q);
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            p_sh_q <= '0;
            d_sh_q <= '0;
            en_q   <= 1'b0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            p_sh_q <= p_sh_d;
            d_sh_q <= d_sh_d;
            en_q   <= en_i;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/wb_pwm_slave.sv
// Wishbone classic slave: register file, shared prescaler, STATUS/IRQ and NCH PWM channels.
module wb_pwm_slave
    import wb_pwm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned NCH       = 4,
    parameter int unsigned CW        = CW_DEFAULT
) (
    input  logic           wb_clk_i,
    input  logic           wb_rstn_i,
    input  logic           wbs_cyc_i,
    input  logic           wbs_stb_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    output logic [NCH-1:0] pwm_o,
    output logic [NCH-1:0] pwm_oeb_o,
    output logic           irq_o
);

    localparam logic [5:0] CTRL_W    = CTRL_OFF[7:2];
    localparam logic [5:0] PRESC_W   = PRESC_OFF[7:2];
    localparam logic [5:0] STATUS_W  = STATUS_OFF[7:2];
    localparam logic [5:0] IRQEN_W   = IRQEN_OFF[7:2];
    localparam logic [5:0] CH_BASE_W = CH_BASE[7:2];
    localparam logic [5:0] CH_SPAN_W = 6'(NCH * (CH_STRIDE >> 2));

    logic [1:0]     rst_sync_q;
    logic           rst_n;
    logic           ack_q, ack_d;
    logic [31:0]    dat_q, dat_d;
    logic [NCH-1:0] en_q, en_d;
    logic [CW-1:0]  presc_q, presc_d;
    logic [CW-1:0]  pcnt_q, pcnt_d;
    logic [NCH-1:0] status_q, status_d;
    logic [NCH-1:0] irqen_q, irqen_d;
    logic [NCH-1:0] oeb_q, oeb_d;
    logic           irq_q, irq_d;
    logic [CW-1:0]  period_q [NCH];
    logic [CW-1:0]  period_d [NCH];
    logic [CW-1:0]  duty_q [NCH];
    logic [CW-1:0]  duty_d [NCH];

    wb_req_t        req;
    logic           req_c;
    logic [5:0]     ch_rel_c;
    logic           ch_hit_c;
    logic           clr_c;
    logic           tick_c;
    logic           any_en_c;
    logic [NCH-1:0] w1c_c;
    logic [NCH-1:0] wrap_c;
    logic [31:0]    rdata_c;
    logic           unused_c;

    assign unused_c = ^wbs_adr_i[1:0];

    // Reset: asserts asynchronously, releases on the clock
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Address decode; ack_q blocks a second request so acks never run back to back
    always_comb begin
        req_c    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
        req.wr   = req_c & wbs_we_i;
        req.sel  = wbs_sel_i;
        req.widx = wbs_adr_i[7:2];
        req.dat  = wbs_dat_i;
        ch_rel_c = req.widx - CH_BASE_W;
        ch_hit_c = (req.widx >= CH_BASE_W) && (ch_rel_c < CH_SPAN_W);
    end

    // Read mux; unmapped offsets return zero
    always_comb begin
        rdata_c = '0;
        case (req.widx)
            CTRL_W:   rdata_c = 32'(en_q);
            PRESC_W:  rdata_c = 32'(presc_q);
            STATUS_W: rdata_c = 32'(status_q);
            IRQEN_W:  rdata_c = 32'(irqen_q);
            default:  ;
        endcase
        for (int unsigned c = 0; c < NCH; c++) begin
            if (ch_hit_c && (ch_rel_c[3:1] == 3'(c)))
                rdata_c = ch_rel_c[0] ? 32'(duty_q[c]) : 32'(period_q[c]);
        end
    end

    // Register writes, prescaler, STATUS and IRQ next state
    always_comb begin
        en_d     = en_q;
        presc_d  = presc_q;
        irqen_d  = irqen_q;
        period_d = period_q;
        duty_d   = duty_q;
        clr_c    = 1'b0;
        w1c_c    = '0;
        if (req.wr) begin
            case (req.widx)
                CTRL_W: begin
                    en_d  = NCH'(merge_bytes(32'(en_q), req.dat, req.sel));
                    clr_c = req.sel[3] & req.dat[CLR_BIT];
                end
                PRESC_W:  presc_d = CW'(merge_bytes(32'(presc_q), req.dat, req.sel));
                STATUS_W: w1c_c   = NCH'(merge_bytes(32'h0, req.dat, req.sel));
                IRQEN_W:  irqen_d = NCH'(merge_bytes(32'(irqen_q), req.dat, req.sel));
                default:  ;
            endcase
            for (int unsigned c = 0; c < NCH; c++) begin
                if (ch_hit_c && (ch_rel_c[3:1] == 3'(c))) begin
                    if (ch_rel_c[0]) duty_d[c]   = CW'(merge_bytes(32'(duty_q[c]), req.dat, req.sel));
                    else             period_d[c] = CW'(merge_bytes(32'(period_q[c]), req.dat, req.sel));
                end
            end
        end
        any_en_c = |en_q;
        // >= keeps the prescaler bounded if PRESC is lowered below the running count
        tick_c   = any_en_c & (pcnt_q >= presc_q) & ~clr_c;
        pcnt_d   = (!any_en_c || clr_c || (pcnt_q >= presc_q)) ? '0 : pcnt_q + CW'(1);
        // Hardware set wins over a simultaneous write-1-to-clear
        status_d = (status_q & ~w1c_c) | wrap_c;
        irq_d    = |(status_d & irqen_d);
        oeb_d    = ~en_d;
        ack_d    = req_c;
        dat_d    = req_c ? rdata_c : '0;
    end

    // Bus, register file and status registers
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            en_q     <= '0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            status_q <= '0;
            irqen_q  <= '0;
            oeb_q    <= '1;
            irq_q    <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                period_q[c] <= '0;
                duty_q[c]   <= '0;
            end
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            status_q <= status_d;
            irqen_q  <= irqen_d;
            oeb_q    <= oeb_d;
            irq_q    <= irq_d;
            period_q <= period_d;
            duty_q   <= duty_d;
        end
    end

    // One channel per output pin
    for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
        pwm_channel #(.CW(CW)) u_ch (
            .clk      (wb_clk_i),
            .rst_n    (rst_n),
            .tick_i   (tick_c),
            .clr_i    (clr_c),
            .en_i     (en_q[g]),
            .period_i (period_q[g]),
            .duty_i   (duty_q[g]),
            .pwm_o    (pwm_o[g]),
            .wrap_c   (wrap_c[g])
        );
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign pwm_oeb_o = oeb_q;
    assign irq_o     = irq_q;

endmodule
